vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates VGA raster timing (horizontal sync, vertical sync, blank) and pixel coordinates from one pixel clock.
- Acts as the source end of the VGA pixel stream: its sync/blank outputs feed the image processing stage's `i_h_sync`/`i_v_sync`/`i_vga_blank` inputs.
- The coordinates let a frame source or pattern generator supply `i_r`/`i_g`/`i_b` aligned with those syncs.
- Optionally produces a colour-bar test pattern for bring-up without a frame source.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CNT_W`, 10, counter/coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^CNT_W

Ports:
- `i_clk`  in  1  pixel clock; one pixel per cycle
- `i_rst_n`  in  1  asynchronous, active-low reset
- `o_h_sync`  out  1  horizontal sync, active low
- `o_v_sync`  out  1  vertical sync, active low
- `o_vga_blank`  out  1  1 during active video, 0 during blanking
- `o_x`  out  CNT_W  current horizontal count
- `o_y`  out  CNT_W  current line count
- `o_frame_start`  out  1  one-cycle pulse on pixel (0,0)
- `o_r`, `o_g`, `o_b`  out  8 each  test-pattern colour

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter `h_cnt`:
  - 0..H_TOTAL-1, increments every clock.
  - Wraps to 0 after H_TOTAL-1.
- Vertical counter `v_cnt`:
  - Increments only on the h_cnt wrap.
  - Wraps to 0 after V_TOTAL-1; a simultaneous h and v wrap gives (0,0).
- Decode, per counter values:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - h_sync low when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - v_sync low when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines
  - frame_start = (h_cnt==0 && v_cnt==0)
- `o_x`/`o_y` carry the raw counters at all times, including blanking; consumers qualify them with `o_vga_blank`.
- No start/enable handshake: the generator free-runs whenever out of reset.

## Timing
- All outputs are registered and decoded from the same counter state, so they are mutually aligned.
- Outputs lag the internal counters by exactly one cycle.
- Reset values (asynchronous, held while `i_rst_n`=0): counters 0, `o_h_sync`=1, `o_v_sync`=1, `o_vga_blank`=0, `o_x`=0, `o_y`=0, `o_frame_start`=0, `o_r`/`o_g`/`o_b`=0.
- First rising edge after reset release: outputs show (0,0), `o_vga_blank`=1, `o_frame_start`=1.
- Steady-state periods:
  - Line: H_TOTAL cycles.
  - Frame: H_TOTAL×V_TOTAL = 420000 cycles.
  - `o_frame_start`: high exactly 1 cycle per frame.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for a clock. Timing restarts at (0,0) with no partial line or frame.

## Configuration
- Macro: `VGA_TEST_PATTERN_EN`.
- Defined:
  - `o_r`/`o_g`/`o_b` output 8 vertical bars, each H_ACTIVE/8 pixels wide.
  - Bar index k (0..7) comes from a bar counter that resets at h_cnt=0 and steps every H_ACTIVE/8 pixels.
  - Colours: `o_r`={8{k[2]}}, `o_g`={8{k[1]}}, `o_b`={8{k[0]}}; bar 0 black, bar 7 white.
  - All colours are 0 whenever `o_vga_blank`=0.
  - Colours are aligned with `o_x`/`o_vga_blank`.
- Not defined: `o_r`/`o_g`/`o_b` are constant 0 and the bar logic is absent. Timing outputs are identical in both builds.

## Test plan
- Reset: hold `i_rst_n`=0 for 5 cycles → h_sync=1, v_sync=1, blank=0, x=y=0, rgb=0. First edge after release → x=0, y=0, blank=1, frame_start=1.
- Line timing: count from x=0 → blank=1 for 640 cycles, then 0 for 160. h_sync falls at x=656 and stays low 96 cycles. x wraps 799→0 while y steps by 1.
- Frame timing: frame_start pulses are exactly 420000 cycles apart. v_sync is low exactly for y=490..491 (1600 cycles). Blank is 0 for all of y=480..524.
- Test pattern (macro defined), line y=0:
  - x=0 → rgb 00/00/00
  - x=80 → 00/00/FF
  - x=320 → FF/00/00
  - x=639 → FF/FF/FF
  - x=640 → 00/00/00
- Macro undefined: rgb stays 0 for a full frame; sync/blank/x/y match the defined build cycle-for-cycle.
- Mid-frame reset at x=300, y=200: outputs take reset values without waiting for a clock edge. After release, the sequence restarts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
// Produces registered h_sync/v_sync (active low), blank (1 = active video),
// raw x/y coordinates and a frame-start pulse, all aligned and one cycle
// behind the internal counters.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern on
// o_r/o_g/o_b; without it the colour outputs are constant zero.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_h_sync,
    output logic             o_v_sync,
    output logic             o_vga_blank,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_frame_start,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    logic             h_sync_n;
    logic             v_sync_n;
    logic             frame_start;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster counters: h every pixel, v on each h wrap; both wrap together at frame end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Decode of the current counter state; registered below so all outputs align.
    always_comb begin
        active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        h_sync_n    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        v_sync_n    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output register: one cycle behind the counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_h_sync      <= 1'b1;
            o_v_sync      <= 1'b1;
            o_vga_blank   <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_h_sync      <= h_sync_n;
            o_v_sync      <= v_sync_n;
            o_vga_blank   <= active;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= frame_start;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    // Pixel position inside the current bar and the bar index; both track h_cnt.
    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_k;

    // Bar counter: restarts with the line, steps every H_ACTIVE/8 pixels.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bar_px <= '0;
            bar_k  <= '0;
        end else if (h_wrap) begin
            bar_px <= '0;
            bar_k  <= '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px <= '0;
            bar_k  <= bar_k + 1'b1;
        end else begin
            bar_px <= bar_px + 1'b1;
        end
    end

    // Colour register, blanked outside active video, aligned with o_x.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r <= '0;
            o_g <= '0;
            o_b <= '0;
        end else begin
            o_r <= active ? {8{bar_k[2]}} : 8'h00;
            o_g <= active ? {8{bar_k[1]}} : 8'h00;
            o_b <= active ? {8{bar_k[0]}} : 8'h00;
        end
    end
`else
    assign o_r = '0;
    assign o_g = '0;
    assign o_b = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen with a reduced
// raster (80 x 19 total) so several frames fit in a short run. A reference
// model derives every output from the number of clock edges since reset
// release; random mid-frame resets are injected on top of fixed checks.
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int CW = 7;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 19
    localparam int FRAME = HT * VT;          // 1520

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          h_sync, v_sync, blank, fs;
    logic [CW-1:0] x, y;
    logic [7:0]    r, g, b;

    int errors = 0;
    int checks = 0;
    int edges;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_h_sync(h_sync), .o_v_sync(v_sync), .o_vga_blank(blank),
        .o_x(x), .o_y(y), .o_frame_start(fs),
        .o_r(r), .o_g(g), .o_b(b)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs after n edges since release (n=0: reset values).
    task automatic model(input int n, output int ex, output int ey, output int ehs,
                         output int evs, output int ebl, output int efs, output int ergb);
        int p, k;
        if (n == 0) begin
            ex = 0; ey = 0; ehs = 1; evs = 1; ebl = 0; efs = 0; ergb = 0;
        end else begin
            p   = (n - 1) % FRAME;
            ex  = p % HT;
            ey  = p / HT;
            ebl = (ex < HA && ey < VA) ? 1 : 0;
            ehs = (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1;
            evs = (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1;
            efs = (p == 0) ? 1 : 0;
            ergb = 0;
`ifdef VGA_TEST_PATTERN_EN
            if (ebl == 1) begin
                k = ex / (HA / 8);
                ergb = ((k & 4) ? 32'hFF0000 : 0) | ((k & 2) ? 32'h00FF00 : 0) | ((k & 1) ? 32'h0000FF : 0);
            end
`else
            k = 0;
`endif
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        int ex, ey, ehs, evs, ebl, efs, ergb;
        model(edges, ex, ey, ehs, evs, ebl, efs, ergb);
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("h_sync", int'(h_sync), ehs);
        chk("v_sync", int'(v_sync), evs);
        chk("blank", int'(blank), ebl);
        chk("frame_start", int'(fs), efs);
        chk("rgb", int'({r, g, b}), ergb);
    end

    // Wait (bounded) until the model edge count reaches n, then sit after the next negedge compare.
    task automatic at_edge(input int n);
        int guard = 0;
        while (edges < n && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("wait_timeout", edges, n);
    endtask

    task automatic pin(input string name, input int n, input int act, input int exp);
        at_edge(n);
        chk(name, act, exp);
    endtask

    int fs_last, fs_gap_seen;

    initial begin
        // Reset held for 5 cycles; compare process checks reset values each cycle.
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;

        at_edge(1);
        chk("pin_first_x", int'(x), 0);
        chk("pin_first_y", int'(y), 0);
        chk("pin_first_blank", int'(blank), 1);
        chk("pin_first_fs", int'(fs), 1);
        at_edge(64);   chk("pin_blank_x63", int'(blank), 1);
`ifdef VGA_TEST_PATTERN_EN
        chk("pin_rgb_x63", int'({r, g, b}), 32'hFFFFFF);
`endif
        at_edge(65);   chk("pin_blank_x64", int'(blank), 0);
`ifdef VGA_TEST_PATTERN_EN
        chk("pin_rgb_x64", int'({r, g, b}), 0);
`endif
        at_edge(68);   chk("pin_hs_x67", int'(h_sync), 1);
        at_edge(69);   chk("pin_hs_x68", int'(h_sync), 0);
        at_edge(76);   chk("pin_hs_x75", int'(h_sync), 0);
        at_edge(77);   chk("pin_hs_x76", int'(h_sync), 1);
        at_edge(80);   chk("pin_wrap_x", int'(x), 79);
        at_edge(81);   chk("pin_line1_x", int'(x), 0);
        chk("pin_line1_y", int'(y), 1);
`ifdef VGA_TEST_PATTERN_EN
        at_edge(81 + 8);  chk("pin_rgb_x8", int'({r, g, b}), 32'h0000FF);
        at_edge(81 + 32); chk("pin_rgb_x32", int'({r, g, b}), 32'hFF0000);
`endif
        at_edge(961);  chk("pin_blank_y12", int'(blank), 0);
        at_edge(1120); chk("pin_vs_y13", int'(v_sync), 1);
        at_edge(1121); chk("pin_vs_y14", int'(v_sync), 0);
        at_edge(1280); chk("pin_vs_y15", int'(v_sync), 0);
        at_edge(1281); chk("pin_vs_y16", int'(v_sync), 1);
        at_edge(1520); chk("pin_last_y", int'(y), 18);
        at_edge(1521); chk("pin_frame2_fs", int'(fs), 1);
        chk("pin_frame2_y", int'(y), 0);

        // Mid-frame reset at x=30, y=5 of the second frame: must act without a clock edge.
        at_edge(FRAME + 5 * HT + 30 + 1);
        chk("pin_mid_x", int'(x), 30);
        chk("pin_mid_y", int'(y), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_blank", int'(blank), 0);
        chk("async_rst_hs", int'(h_sync), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        at_edge(1);
        chk("restart_fs", int'(fs), 1);
        chk("restart_x", int'(x), 0);

        // Random run lengths and reset placements.
        for (int i = 0; i < 8; i++) begin
            at_edge(int'($urandom_range(50, 2 * FRAME)));
            @(negedge clk);
            #($urandom_range(1, 4) + ($urandom_range(0, 1) ? 5 : 0));
            rst_n = 1'b0;
            #1;
            chk("rand_rst_x", int'(x), 0);
            chk("rand_rst_fs", int'(fs), 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #($urandom_range(1, 4));
            rst_n = 1'b1;
        end

        // Frame-start spacing over a clean stretch.
        at_edge(1);
        fs_last = 1;
        fs_gap_seen = 0;
        for (int n = 2; n <= 2 * FRAME + 1; n++) begin
            at_edge(n);
            if (fs) begin
                chk("fs_period", n - fs_last, FRAME);
                fs_last = n;
                fs_gap_seen++;
            end
        end
        chk("fs_pulses", fs_gap_seen, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
